// File: rtl/vga_pkg.sv
// Shared timing types, stock VGA modes and the config validity check for vga_timing_engine.
package vga_pkg;

    localparam int TIM_W = 12;

    typedef struct packed {
        logic [TIM_W-1:0] h_vis;
        logic [TIM_W-1:0] h_fp;
        logic [TIM_W-1:0] h_sp;
        logic [TIM_W-1:0] h_bp;
        logic [TIM_W-1:0] v_vis;
        logic [TIM_W-1:0] v_fp;
        logic [TIM_W-1:0] v_sp;
        logic [TIM_W-1:0] v_bp;
        logic             h_pol;
        logic             v_pol;
    } timing_t;

    localparam timing_t VGA_640X480_60 = '{
        h_vis: 12'd640, h_fp: 12'd16, h_sp: 12'd96, h_bp: 12'd48,
        v_vis: 12'd480, v_fp: 12'd10, v_sp: 12'd2,  v_bp: 12'd33,
        h_pol: 1'b0,    v_pol: 1'b0};

    localparam timing_t VGA_800X600_60 = '{
        h_vis: 12'd800, h_fp: 12'd40, h_sp: 12'd128, h_bp: 12'd88,
        v_vis: 12'd600, v_fp: 12'd1,  v_sp: 12'd4,   v_bp: 12'd23,
        h_pol: 1'b1,    v_pol: 1'b1};

    // Every field non-zero and both totals representable in TIM_W bits.
    function automatic logic timing_ok(input timing_t t);
        logic [TIM_W+1:0] ht, vt;
        ht = (TIM_W+2)'(t.h_vis) + (TIM_W+2)'(t.h_fp) + (TIM_W+2)'(t.h_sp) + (TIM_W+2)'(t.h_bp);
        vt = (TIM_W+2)'(t.v_vis) + (TIM_W+2)'(t.v_fp) + (TIM_W+2)'(t.v_sp) + (TIM_W+2)'(t.v_bp);
        return (t.h_vis != '0) && (t.h_fp != '0) && (t.h_sp != '0) && (t.h_bp != '0) &&
               (t.v_vis != '0) && (t.v_fp != '0) && (t.v_sp != '0) && (t.v_bp != '0) &&
               (ht[TIM_W+1:TIM_W] == 2'b00) && (vt[TIM_W+1:TIM_W] == 2'b00);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping coordinate counter with registered visible/pulse decode of the next coordinate.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic [CW-1:0] vis_len,
    input  logic [CW-1:0] fp_len,
    input  logic [CW-1:0] sp_len,
    input  logic [CW-1:0] bp_len,
    output logic [CW-1:0] coord,
    output logic          wrap,
    output logic          vis,
    output logic          pulse
);

    logic [CW-1:0] coord_q, coord_d;
    logic [CW-1:0] total, sp_start, sp_end;
    logic          vis_q, pulse_q;

    assign total    = vis_len + fp_len + sp_len + bp_len;
    assign sp_start = vis_len + fp_len;
    assign sp_end   = sp_start + sp_len;
    assign wrap     = inc && (coord_q == total - 1'b1);

    always_comb begin
        coord_d = coord_q;
        if (inc) coord_d = wrap ? '0 : coord_q + 1'b1;
    end

    // Decode at coord 0 is always vis=1/pulse=0, so a timing swap on wrap cannot skew it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coord_q <= '0;
            vis_q   <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            coord_q <= coord_d;
            vis_q   <= (coord_d < vis_len);
            pulse_q <= (coord_d >= sp_start) && (coord_d < sp_end);
        end
    end

    assign coord = coord_q;
    assign vis   = vis_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/vga_timing_engine.sv
// Reprogrammable VGA timing generator; shadowed config applied at frame wrap.
// Optional frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int      CW         = 12,
    parameter int      IDX_W      = 20,
    parameter int      PIX_DIV    = 1,
    parameter timing_t DEF_TIMING = VGA_640X480_60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  timing_t          cfg,
    output logic             cfg_err,
    output logic             pix_en,
    output logic [CW-1:0]    h_coord,
    output logic [CW-1:0]    v_coord,
    output logic [IDX_W-1:0] idx,
    output logic             h_sync,
    output logic             v_sync,
    output logic             valid,
    output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             frame_start
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0]    div_q, div_d;
    logic             adv;
    timing_t          tim_q, tim_d, shd_q, shd_d;
    logic             full_q, full_d, rdy_q, err_q, pe_q;
    logic             ls_q, ls_d, fs_q, fs_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             h_wrap, v_wrap, h_vis, v_vis, h_pulse, v_pulse;
    logic             frame_wrap, xfer, accept, apply;

    assign adv        = (div_q == DW'(PIX_DIV - 1));
    assign div_d      = adv ? '0 : div_q + 1'b1;
    assign frame_wrap = h_wrap && v_wrap;
    assign xfer       = cfg_valid && rdy_q;
    assign accept     = xfer && timing_ok(cfg);
    assign apply      = frame_wrap && full_q;

    vga_axis_counter #(.CW(CW)) u_h (
        .clk(clk), .reset(reset), .inc(adv),
        .vis_len(CW'(tim_q.h_vis)), .fp_len(CW'(tim_q.h_fp)),
        .sp_len(CW'(tim_q.h_sp)), .bp_len(CW'(tim_q.h_bp)),
        .coord(h_coord), .wrap(h_wrap), .vis(h_vis), .pulse(h_pulse));

    vga_axis_counter #(.CW(CW)) u_v (
        .clk(clk), .reset(reset), .inc(h_wrap),
        .vis_len(CW'(tim_q.v_vis)), .fp_len(CW'(tim_q.v_fp)),
        .sp_len(CW'(tim_q.v_sp)), .bp_len(CW'(tim_q.v_bp)),
        .coord(v_coord), .wrap(v_wrap), .vis(v_vis), .pulse(v_pulse));

    always_comb begin
        tim_d  = apply ? shd_q : tim_q;
        shd_d  = accept ? cfg : shd_q;
        full_d = accept || (full_q && !apply);
        idx_d  = idx_q;
        if (frame_wrap)         idx_d = '0;
        else if (adv && valid)  idx_d = idx_q + 1'b1;
        ls_d   = adv ? h_wrap : ls_q;
        fs_d   = adv ? frame_wrap : fs_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tim_q  <= DEF_TIMING;
            shd_q  <= '0;
            full_q <= 1'b0;
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            pe_q   <= 1'b0;
            idx_q  <= '0;
            ls_q   <= 1'b1;
            fs_q   <= 1'b1;
        end else begin
            div_q  <= div_d;
            tim_q  <= tim_d;
            shd_q  <= shd_d;
            full_q <= full_d;
            rdy_q  <= !full_d;
            err_q  <= xfer && !timing_ok(cfg);
            pe_q   <= adv;
            idx_q  <= idx_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fcnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           fcnt_q <= '0;
        else if (frame_wrap) fcnt_q <= fcnt_q + 16'd1;
    end
    assign frame_cnt = fcnt_q;
`endif

    assign cfg_ready   = rdy_q;
    assign cfg_err     = err_q;
    assign pix_en      = pe_q;
    assign idx         = idx_q;
    assign valid       = h_vis && v_vis;
    assign h_sync      = ~(h_pulse ^ tim_q.h_pol);
    assign v_sync      = ~(v_pulse ^ tim_q.v_pol);
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench: default 640x480 mode, PIX_DIV=3, and a small mode exercising config, apply and reset.
module tb_vga_timing_engine;
    import vga_pkg::*;

    localparam timing_t SMALL = '{
        h_vis: 12'd8, h_fp: 12'd2, h_sp: 12'd3, h_bp: 12'd3,
        v_vis: 12'd6, v_fp: 12'd1, v_sp: 12'd2, v_bp: 12'd1,
        h_pol: 1'b0,  v_pol: 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    logic    cv0 = 1'b0;
    timing_t cfg0 = '0;
    logic    s_cv;
    timing_t s_cfg, bad;

    logic        d_rdy, d_err, d_pe, d_hs, d_vs, d_vl, d_ls, d_fs;
    logic [11:0] d_h, d_v;
    logic [19:0] d_idx;
    logic        t_rdy, t_err, t_pe, t_hs, t_vs, t_vl, t_ls, t_fs;
    logic [11:0] t_h, t_v;
    logic [19:0] t_idx;
    logic        s_rdy, s_err, s_pe, s_hs, s_vs, s_vl, s_ls, s_fs;
    logic [11:0] s_h, s_v;
    logic [19:0] s_idx;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d_fc, t_fc, s_fc;
`endif

    vga_timing_engine u_def (
        .clk(clk), .reset(reset), .cfg_valid(cv0), .cfg_ready(d_rdy), .cfg(cfg0),
        .cfg_err(d_err), .pix_en(d_pe), .h_coord(d_h), .v_coord(d_v), .idx(d_idx),
        .h_sync(d_hs), .v_sync(d_vs), .valid(d_vl), .line_start(d_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(d_fc),
`endif
        .frame_start(d_fs));

    vga_timing_engine #(.PIX_DIV(3)) u_div3 (
        .clk(clk), .reset(reset), .cfg_valid(cv0), .cfg_ready(t_rdy), .cfg(cfg0),
        .cfg_err(t_err), .pix_en(t_pe), .h_coord(t_h), .v_coord(t_v), .idx(t_idx),
        .h_sync(t_hs), .v_sync(t_vs), .valid(t_vl), .line_start(t_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(t_fc),
`endif
        .frame_start(t_fs));

    vga_timing_engine #(.DEF_TIMING(SMALL)) u_small (
        .clk(clk), .reset(reset), .cfg_valid(s_cv), .cfg_ready(s_rdy), .cfg(s_cfg),
        .cfg_err(s_err), .pix_en(s_pe), .h_coord(s_h), .v_coord(s_v), .idx(s_idx),
        .h_sync(s_hs), .v_sync(s_vs), .valid(s_vl), .line_start(s_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(s_fc),
`endif
        .frame_start(s_fs));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic chk_rst(input string p, input logic [11:0] h, input logic [11:0] v,
                           input logic [19:0] ix, input logic hs, input logic vs,
                           input logic vl, input logic pe, input logic ls, input logic fs,
                           input logic rdy, input logic err);
        chk({p, ".h"}, 32'(h), 0);
        chk({p, ".v"}, 32'(v), 0);
        chk({p, ".idx"}, 32'(ix), 0);
        chk({p, ".h_sync"}, 32'(hs), 1);
        chk({p, ".v_sync"}, 32'(vs), 1);
        chk({p, ".valid"}, 32'(vl), 1);
        chk({p, ".pix_en"}, 32'(pe), 0);
        chk({p, ".line_start"}, 32'(ls), 1);
        chk({p, ".frame_start"}, 32'(fs), 1);
        chk({p, ".cfg_ready"}, 32'(rdy), 0);
        chk({p, ".cfg_err"}, 32'(err), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    task automatic send_cfg(input timing_t c);
        s_cfg = c;
        s_cv  = 1'b1;
        tick();
        s_cv  = 1'b0;
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, dpe_bad, tbad;
        hs_cnt = 0; hs_first = -1; hs_last = -1; dpe_bad = 0; tbad = 0;
        s_cv = 1'b0; s_cfg = '0;
        bad = SMALL;
        bad.h_sp = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_rst("def_rst", d_h, d_v, d_idx, d_hs, d_vs, d_vl, d_pe, d_ls, d_fs, d_rdy, d_err);
        chk("div3_rst.pix_en", 32'(t_pe), 0);
        reset = 1'b0;
        k = 0;

        // Default mode and PIX_DIV=3 observed side by side
        for (int i = 1; i <= 2450; i++) begin
            tick();
            if (i < 800 && d_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_h);
                hs_last = int'(d_h);
            end
            if (d_pe !== 1'b1) dpe_bad++;
            if (i < 2400 && (int'(t_h) != i / 3 || t_v != 12'd0 || t_pe !== (i % 3 == 0))) tbad++;
            case (i)
                1:    chk("def.cfg_ready_rise", 32'(d_rdy), 1);
                639:  begin chk("def.idx_639", 32'(d_idx), 639); chk("def.valid_639", 32'(d_vl), 1); end
                640:  chk("def.valid_640", 32'(d_vl), 0);
                800:  begin
                    chk("def.line_h", 32'(d_h), 0);
                    chk("def.line_v", 32'(d_v), 1);
                    chk("def.line_start", 32'(d_ls), 1);
                    chk("def.frame_start_l1", 32'(d_fs), 0);
                    chk("def.idx_line1", 32'(d_idx), 640);
                    chk("def.v_sync_l1", 32'(d_vs), 1);
                end
                2399: chk("div3.h_2399", 32'(t_h), 799);
                2400: begin
                    chk("div3.line_h", 32'(t_h), 0);
                    chk("div3.line_v", 32'(t_v), 1);
                    chk("div3.pix_en_2400", 32'(t_pe), 1);
                end
                default: ;
            endcase
        end
        chk("def.hs_low_count", 32'(hs_cnt), 96);
        chk("def.hs_low_first", 32'(hs_first), 656);
        chk("def.hs_low_last", 32'(hs_last), 751);
        chk("def.pix_en_bad", 32'(dpe_bad), 0);
        chk("div3.hold_bad", 32'(tbad), 0);

        // Small mode: 16 x 10 totals, h pulse 10..12, v pulse 7..8
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        run_to(9);   chk("s.hs_9", 32'(s_hs), 1);
        run_to(10);  chk("s.hs_10", 32'(s_hs), 0);
        run_to(13);  chk("s.hs_13", 32'(s_hs), 1);
        run_to(87);  chk("s.idx_last_vis", 32'(s_idx), 47); chk("s.valid_87", 32'(s_vl), 1);
        run_to(88);  chk("s.valid_88", 32'(s_vl), 0);
        run_to(111); chk("s.vs_line6", 32'(s_vs), 1);
        run_to(112); chk("s.vs_line7", 32'(s_vs), 0);
        run_to(143); chk("s.vs_line8", 32'(s_vs), 0);
        run_to(144); chk("s.vs_line9", 32'(s_vs), 1);
        run_to(159); chk("s.h_159", 32'(s_h), 15); chk("s.v_159", 32'(s_v), 9);
        run_to(160);
        chk("s.frame_h", 32'(s_h), 0);
        chk("s.frame_v", 32'(s_v), 0);
        chk("s.frame_start", 32'(s_fs), 1);
        chk("s.idx_wrap", 32'(s_idx), 0);

        run_to(165);
        send_cfg(bad);
        chk("s.rej.cfg_err", 32'(s_err), 1);
        chk("s.rej.cfg_ready", 32'(s_rdy), 1);
        tick();
        chk("s.rej.err_pulse", 32'(s_err), 0);
        run_to(320); chk("s.rej.frame_start", 32'(s_fs), 1);
        run_to(336); chk("s.rej.line_h", 32'(s_h), 0); chk("s.rej.line_v", 32'(s_v), 1);

        run_to(340);
        send_cfg(VGA_800X600_60);
        chk("s.load.cfg_ready", 32'(s_rdy), 0);
        chk("s.load.cfg_err", 32'(s_err), 0);
        run_to(479);
        chk("s.load.old_h", 32'(s_h), 15);
        chk("s.load.old_v", 32'(s_v), 9);
        chk("s.load.ready_before", 32'(s_rdy), 0);
        run_to(480);
        chk("s.apply.frame_start", 32'(s_fs), 1);
        chk("s.apply.cfg_ready", 32'(s_rdy), 1);
        chk("s.apply.h_sync_idle", 32'(s_hs), 0);
        chk("s.apply.v_sync_idle", 32'(s_vs), 0);
        chk("s.apply.idx", 32'(s_idx), 0);
        run_to(1279); chk("s.new.valid_799", 32'(s_vl), 1);
        run_to(1280); chk("s.new.valid_800", 32'(s_vl), 0);
        run_to(1319); chk("s.new.hs_839", 32'(s_hs), 0);
        run_to(1320); chk("s.new.hs_840", 32'(s_hs), 1);
        run_to(1447); chk("s.new.hs_967", 32'(s_hs), 1);
        run_to(1448); chk("s.new.hs_968", 32'(s_hs), 0);
        run_to(1536); chk("s.new.line_h", 32'(s_h), 0); chk("s.new.line_v", 32'(s_v), 1);

        run_to(1540);
        send_cfg(SMALL);
        chk("s.shadow_full.ready", 32'(s_rdy), 0);
        run_to(1545);
        reset = 1'b1;
        #2;
        chk_rst("s_async_rst", s_h, s_v, s_idx, s_hs, s_vs, s_vl, s_pe, s_ls, s_fs, s_rdy, s_err);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        run_to(1);   chk("s.post.cfg_ready", 32'(s_rdy), 1);
        run_to(16);  chk("s.post.line_h", 32'(s_h), 0); chk("s.post.line_v", 32'(s_v), 1);
        run_to(160); chk("s.post.frame_start", 32'(s_fs), 1);
        run_to(176); chk("s.post.f2_line_h", 32'(s_h), 0); chk("s.post.f2_line_v", 32'(s_v), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
